// File: rtl/md_sequencer_if.sv
// Operand/control bundle between the ID/EX pipeline register and md_sequencer.
// master drives the EX-stage controls; slave (the sequencer) returns Busy and HI/LO.
interface md_sequencer_if;
   logic        Start_E;
   logic [1:0]  MDControl_E;
   logic        MDWrite_E;
   logic        HiLo_E;
   logic [31:0] SrcA_E;
   logic [31:0] SrcB_E;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start_E, MDControl_E, MDWrite_E, HiLo_E, SrcA_E, SrcB_E,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start_E, MDControl_E, MDWrite_E, HiLo_E, SrcA_E, SrcB_E,
      output Busy, HI, LO
   );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide sequencer owning the architectural HI/LO registers.
// Optional MD_FAST_DIVZERO_EN: divide by zero finishes in one Busy cycle with HI/LO unchanged.
module md_sequencer #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic            clk,
   input  logic            reset,
   md_sequencer_if.slave   md
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pendHi_q, pendHi_d;
   logic [31:0]      pendLo_q, pendLo_d;

   logic             isDiv, isSigned, divZero, negA, negB;
   logic [31:0]      magA, magB, divisor, quoMag, remMag, quo, rem;
   logic [63:0]      extA, extB, product, result;
   logic [CNT_W-1:0] startCnt;

   // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
   always_comb begin
      isDiv    = md.MDControl_E[1];
      isSigned = ~md.MDControl_E[0];
      divZero  = (md.SrcB_E == 32'd0);

      extA    = {{32{isSigned & md.SrcA_E[31]}}, md.SrcA_E};
      extB    = {{32{isSigned & md.SrcB_E[31]}}, md.SrcB_E};
      product = extA * extB;

      negA    = isSigned & md.SrcA_E[31];
      negB    = isSigned & md.SrcB_E[31];
      magA    = negA ? (~md.SrcA_E + 32'd1) : md.SrcA_E;
      magB    = negB ? (~md.SrcB_E + 32'd1) : md.SrcB_E;
      divisor = divZero ? 32'd1 : magB;
      quoMag  = magA / divisor;
      remMag  = magA % divisor;
      quo     = (negA ^ negB) ? (~quoMag + 32'd1) : quoMag;
      rem     = negA ? (~remMag + 32'd1) : remMag;

      result   = isDiv ? {rem, quo} : product;
      startCnt = isDiv ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
`ifdef MD_FAST_DIVZERO_EN
      if (isDiv && divZero) begin
         result   = {hi_q, lo_q};
         startCnt = '0;
      end
`else
      if (isDiv && divZero) begin
         result = {md.SrcA_E, 32'hFFFF_FFFF};
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      pendHi_d = pendHi_q;
      pendLo_d = pendLo_q;
      case (state_q)
         IDLE: begin
            if (md.Start_E) begin
               {pendHi_d, pendLo_d} = result;
               cnt_d                = startCnt;
               state_d              = RUN;
            end else if (md.MDWrite_E) begin
               if (md.HiLo_E) hi_d = md.SrcA_E;
               else           lo_d = md.SrcA_E;
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               hi_d    = pendHi_q;
               lo_d    = pendLo_q;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         pendHi_q <= '0;
         pendLo_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         pendHi_q <= pendHi_d;
         pendLo_q <= pendLo_d;
      end
   end

   assign md.Busy = (state_q == RUN);
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, arithmetic, mthi/mtlo, reset and divide-by-zero.
// Expected divide-by-zero behaviour follows MD_FAST_DIVZERO_EN when it is defined.
module tb_md_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   busyCycles;
   logic [31:0] hiEarly;

   md_sequencer_if bus();

   md_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   always #5 clk = ~clk;

   // The hazard unit never issues Start or mthi/mtlo while Busy is high.
   always @(posedge clk) begin
      if (reset && bus.Busy) assert (!(bus.Start_E || bus.MDWrite_E));
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; launches one op, scrambles operands after the start edge,
   // and returns at the first negedge where Busy reads 0 again.
   task automatic applyStimulus(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                output int cycles, output logic [31:0] firstHi);
      bus.Start_E     = 1'b1;
      bus.MDControl_E = ctl;
      bus.SrcA_E      = a;
      bus.SrcB_E      = b;
      cycles          = 0;
      @(negedge clk);
      firstHi       = bus.HI;
      bus.Start_E   = 1'b0;
      bus.MDWrite_E = 1'b0;
      bus.SrcA_E    = ~a;
      bus.SrcB_E    = ~b;
      for (int i = 0; i < 40; i++) begin
         if (!bus.Busy) break;
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic runCase(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input int expLat,
                          input logic [31:0] expHi, input logic [31:0] expLo);
      logic [31:0] unusedHi;
      applyStimulus(ctl, a, b, busyCycles, unusedHi);
      checkOutput({tag, "_busy"}, 32'(busyCycles), 32'(expLat));
      checkOutput({tag, "_hi"}, bus.HI, expHi);
      checkOutput({tag, "_lo"}, bus.LO, expLo);
   endtask

   initial begin
      bus.Start_E     = 1'b0;
      bus.MDControl_E = 2'b00;
      bus.MDWrite_E   = 1'b0;
      bus.HiLo_E      = 1'b0;
      bus.SrcA_E      = 32'd0;
      bus.SrcB_E      = 32'd0;
      reset           = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {31'd0, bus.Busy}, 32'd0);
      checkOutput("rst_hi", bus.HI, 32'd0);
      checkOutput("rst_lo", bus.LO, 32'd0);
      reset = 1'b1;

      runCase("mult",  2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      runCase("multu", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      runCase("div",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runCase("divNegB", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
      runCase("divu",  2'b11, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);

      bus.MDWrite_E = 1'b1;
      bus.HiLo_E    = 1'b0;
      bus.SrcA_E    = 32'h1234_5678;
      @(negedge clk);
      bus.MDWrite_E = 1'b0;
      bus.SrcA_E    = 32'hA5A5_A5A5;
      checkOutput("mtlo_lo", bus.LO, 32'h1234_5678);
      checkOutput("mtlo_hi", bus.HI, 32'h0000_0001);
      checkOutput("mtlo_busy", {31'd0, bus.Busy}, 32'd0);

      bus.MDWrite_E = 1'b1;
      bus.HiLo_E    = 1'b1;
      applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h0000_0002, busyCycles, hiEarly);
      checkOutput("mthiStart_dropped", hiEarly, 32'h0000_0001);
      checkOutput("mthiStart_busy", 32'(busyCycles), 32'd5);
      checkOutput("mthiStart_hi", bus.HI, 32'hFFFF_FFFF);
      checkOutput("mthiStart_lo", bus.LO, 32'hBD5B_7DDE);

      runCase("divMinByNeg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

`ifdef MD_FAST_DIVZERO_EN
      runCase("divZero", 2'b10, 32'h0000_0005, 32'h0000_0000, 1, 32'h0000_0000, 32'h8000_0000);
`else
      runCase("divZero", 2'b10, 32'h0000_0005, 32'h0000_0000, 10, 32'h0000_0005, 32'hFFFF_FFFF);
`endif

      runCase("b2bMultu", 2'b01, 32'd3, 32'd4, 5, 32'd0, 32'd12);
      runCase("b2bDivu",  2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14);

      bus.Start_E     = 1'b1;
      bus.MDControl_E = 2'b00;
      bus.SrcA_E      = 32'd3;
      bus.SrcB_E      = 32'd4;
      @(negedge clk);
      bus.Start_E = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checkOutput("midRst_busy", {31'd0, bus.Busy}, 32'd0);
      checkOutput("midRst_hi", bus.HI, 32'd0);
      checkOutput("midRst_lo", bus.LO, 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("midRst_noCommitHi", bus.HI, 32'd0);
      checkOutput("midRst_noCommitLo", bus.LO, 32'd0);
      checkOutput("midRst_idle", {31'd0, bus.Busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the EX stage. Samples the Start/MDControl/MDWrite/HiLo controls and forwarded operands leaving the ID/EX pipeline register, runs the operation for a fixed, parameterised number of cycles, and owns the architectural HI/LO registers. Drives Busy to the hazard unit, which stalls any multiply/divide instruction, mfhi/mflo or mthi/mtlo in D while `Start_E | Busy` is high.

## Interface
- MUL_LAT, 5, Busy cycles for mult/multu (≥1)
- DIV_LAT, 10, Busy cycles for div/divu (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk)
- Start_E  input  1  launch operation selected by MDControl_E
- MDControl_E  input  2  00 mult, 01 multu, 10 div, 11 divu
- MDWrite_E  input  1  mthi/mtlo write
- HiLo_E  input  1  mthi/mtlo target: 1 HI, 0 LO
- SrcA_E  input  32  forwarded rs operand (multiplicand / dividend / mthi-mtlo data)
- SrcB_E  input  32  forwarded rt operand (multiplier / divisor)
- Busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- States: IDLE, RUN.
- IDLE, Start_E=1: compute 64-bit result into pending registers (pend_hi, pend_lo), load cnt = LAT−1 (LAT per op class), go RUN.
- IDLE, MDWrite_E=1, Start_E=0: write SrcA_E to HI (HiLo_E=1) or LO (HiLo_E=0) at that edge; stay IDLE.
- IDLE, Start_E and MDWrite_E both high: Start wins, write dropped.
- RUN: cnt decrements each cycle; on the edge where cnt==0, HI←pend_hi, LO←pend_lo, go IDLE.
- RUN: Start_E and MDWrite_E ignored (hazard unit guarantees none; bench asserts).
- Arithmetic: mult {HI,LO} = signed 32×32→64; multu unsigned. div LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu unsigned. 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: see Configuration.
- HI/LO never change except at RUN completion, accepted mthi/mtlo, or reset.

## Timing
- Reset (reset=0 at an edge): state IDLE, cnt=0, Busy=0, HI=0, LO=0, pending discarded. Applies mid-RUN; no result is committed.
- Busy is registered: low in the cycle Start_E is sampled, high for exactly LAT cycles afterwards, low again in the cycle HI/LO show the new result.
- Result latency: Start sampled at edge t → HI/LO updated at edge t+LAT.
- Back-to-back: Start may be accepted in the cycle Busy first reads 0 again.
- mthi/mtlo latency: 1 edge; new value visible the following cycle.
- Operands are sampled only at the Start edge; later SrcA_E/SrcB_E changes have no effect.

## Configuration
- MD_FAST_DIVZERO_EN defined: div/divu with SrcB_E=0 keeps HI/LO unchanged, enters RUN with cnt=0 (Busy high exactly 1 cycle).
- Undefined: divide by zero runs the full DIV_LAT; commits LO=0xFFFFFFFF, HI=SrcA_E.

## Test plan
- mult SrcA=0xFFFFFFFE (−2), SrcB=0x00000003 → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div SrcA=0xFFFFFFF9 (−7), SrcB=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- mtlo 0x12345678 in IDLE → LO=0x12345678 next cycle, HI unchanged, Busy stays 0. mthi 0xDEADBEEF with Start_E also high → write dropped, multiply runs.
- Start mult, drive reset=0 in RUN cycle 3 → Busy=0, HI=LO=0 next cycle; no later commit.
- div by zero SrcA=5: with MD_FAST_DIVZERO_EN, Busy 1 cycle, HI/LO unchanged; without, Busy 10 cycles, LO=0xFFFFFFFF, HI=5.
- Back-to-back: multu 3×4 then divu 100/7 launched the first cycle Busy=0 → HI=0,LO=12 after 5 cycles; then LO=14, HI=2 after further 10.
